ldpc_cnu_serial: RTL and testbench

LDPC_CNU_SERIAL -- requirements
Module: ldpc_cnu_serial

---
 rtl/ldpc_cnu_serial.sv | 164 ++++++++++++++++
 tb/tb_ldpc_cnu_serial.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_cnu_serial.sv
// Serial min-sum LDPC check-node unit: collects deg messages, then emits deg extrinsic replies.
// Define LDPC_CNU_OFFSET_EN for offset min-sum (adds beta port); default is normalized (0.75).
module ldpc_cnu_serial #(
  parameter int MSG_WIDTH = 6,
  parameter int MAX_DEG   = 32,
  parameter int DEG_W     = $clog2(MAX_DEG) + 1,
  parameter int IDX_W     = $clog2(MAX_DEG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DEG_W-1:0]     deg,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MSG_WIDTH-1:0] in_msg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MSG_WIDTH-1:0] out_msg,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 busy,
  output logic                 deg_err
`ifdef LDPC_CNU_OFFSET_EN
  ,
  input  logic [MSG_WIDTH-2:0] beta
`endif
);

  localparam int MAG_W = MSG_WIDTH - 1;
  localparam logic [MAG_W-1:0] LP_MAG_MAX = '1;
  localparam logic [DEG_W-1:0] LP_DEG_MIN = DEG_W'(2);
  localparam logic [DEG_W-1:0] LP_DEG_MAX = DEG_W'(MAX_DEG);

  typedef enum logic [1:0] {StIdle, StCollect, StEmit} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [DEG_W-1:0] r_deg;
  logic [DEG_W-1:0] r_cnt;
  logic [MAG_W-1:0] r_min1;
  logic [MAG_W-1:0] r_min2;
  logic [IDX_W-1:0] r_idx1;
  logic             r_sign_total;
  logic             r_deg_err;
  logic             r_sign [MAX_DEG];

  logic                 w_deg_ok;
  logic                 w_start_ok;
  logic                 w_start_bad;
  logic                 w_in_hs;
  logic                 w_out_hs;
  logic                 w_last;
  logic [IDX_W-1:0]     w_idx;
  logic [MSG_WIDTH-1:0] w_abs;
  logic [MAG_W-1:0]     w_in_mag;
  logic [MAG_W-1:0]     w_raw;
  logic [MAG_W-1:0]     w_mag_out;
  logic [MSG_WIDTH-1:0] w_out_pos;
  logic                 w_out_neg;

  assign w_deg_ok    = (deg >= LP_DEG_MIN) && (deg <= LP_DEG_MAX);
  assign w_start_ok  = (r_state == StIdle) && start && w_deg_ok;
  assign w_start_bad = (r_state == StIdle) && start && !w_deg_ok;
  assign w_in_hs     = (r_state == StCollect) && in_valid;
  assign w_out_hs    = (r_state == StEmit) && out_ready;
  assign w_last      = (r_cnt == (r_deg - DEG_W'(1)));
  assign w_idx       = r_cnt[IDX_W-1:0];

  // Only the most-negative input leaves the top bit of w_abs set; saturate it.
  always_comb begin
    w_abs    = in_msg[MSG_WIDTH-1] ? -in_msg : in_msg;
    w_in_mag = w_abs[MSG_WIDTH-1] ? LP_MAG_MAX : w_abs[MAG_W-1:0];
  end

  assign w_raw = (w_idx == r_idx1) ? r_min2 : r_min1;

`ifdef LDPC_CNU_OFFSET_EN
  assign w_mag_out = (w_raw > beta) ? (w_raw - beta) : '0;
`else
  logic [MAG_W+1:0] w_mul3;
  assign w_mul3    = {2'b00, w_raw} + {1'b0, w_raw, 1'b0};
  assign w_mag_out = MAG_W'(w_mul3 >> 2);
`endif

  assign w_out_pos = {1'b0, w_mag_out};
  assign w_out_neg = r_sign_total ^ r_sign[w_idx];

  assign in_ready  = (r_state == StCollect);
  assign out_valid = (r_state == StEmit);
  assign busy      = (r_state != StIdle);
  assign deg_err   = r_deg_err;
  assign out_msg   = (r_state != StEmit) ? '0 : (w_out_neg ? -w_out_pos : w_out_pos);
  assign out_idx   = (r_state == StEmit) ? w_idx : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (w_start_ok) w_state_next = StCollect;
      StCollect: if (w_in_hs && w_last) w_state_next = StEmit;
      StEmit:    if (w_out_hs && w_last) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deg        <= '0;
      r_cnt        <= '0;
      r_min1       <= LP_MAG_MAX;
      r_min2       <= LP_MAG_MAX;
      r_idx1       <= '0;
      r_sign_total <= 1'b0;
      r_deg_err    <= 1'b0;
    end else begin
      r_deg_err <= w_start_bad;
      case (r_state)
        StIdle: begin
          if (w_start_ok) begin
            r_deg        <= deg;
            r_cnt        <= '0;
            r_min1       <= LP_MAG_MAX;
            r_min2       <= LP_MAG_MAX;
            r_idx1       <= '0;
            r_sign_total <= 1'b0;
          end
        end
        StCollect: begin
          if (w_in_hs) begin
            r_cnt        <= w_last ? '0 : r_cnt + DEG_W'(1);
            r_sign_total <= r_sign_total ^ in_msg[MSG_WIDTH-1];
            // Strict compares keep the first index on ties.
            if (w_in_mag < r_min1) begin
              r_min2 <= r_min1;
              r_min1 <= w_in_mag;
              r_idx1 <= w_idx;
            end else if (w_in_mag < r_min2) begin
              r_min2 <= w_in_mag;
            end
          end
        end
        StEmit: begin
          if (w_out_hs) begin
            r_cnt <= w_last ? '0 : r_cnt + DEG_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_sign[w_idx] <= in_msg[MSG_WIDTH-1];
    end
  end

endmodule

// File: tb/tb_ldpc_cnu_serial.sv
// Scoreboard bench for ldpc_cnu_serial; reference computes each extrinsic reply directly
// as the corrected minimum / sign product over all other edges of the row.
module tb_ldpc_cnu_serial;

  localparam int W    = 6;
  localparam int MAXD = 32;
  localparam int DW   = 6;
  localparam int IW   = 5;
  localparam int MAGMAX = (1 << (W - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] deg;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_msg;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_msg;
  logic [IW-1:0] out_idx;
  logic          busy;
  logic          deg_err;
`ifdef LDPC_CNU_OFFSET_EN
  logic [W-2:0]  beta;
`endif

  ldpc_cnu_serial #(
    .MSG_WIDTH(W),
    .MAX_DEG  (MAXD),
    .DEG_W    (DW),
    .IDX_W    (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .deg      (deg),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_msg   (in_msg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_msg  (out_msg),
    .out_idx  (out_idx),
    .busy     (busy),
    .deg_err  (deg_err)
`ifdef LDPC_CNU_OFFSET_EN
    ,
    .beta     (beta)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int msg;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   g_msgs[MAXD];
  int   g_beta = 0;
  int   rdy_pct = 100;
  int   force_hold = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int corr(input int x);
`ifdef LDPC_CNU_OFFSET_EN
    return (x > g_beta) ? x - g_beta : 0;
`else
    return (3 * x) / 4;
`endif
  endfunction

  // Extrinsic reply for edge j: min magnitude and sign parity over all k != j.
  function automatic void push_expected(input int d);
    for (int j = 0; j < d; j++) begin
      int   m;
      bit   s;
      int   c;
      exp_t e;
      m = MAGMAX;
      s = 1'b0;
      for (int k = 0; k < d; k++) begin
        if (k != j) begin
          int a;
          a = (g_msgs[k] < 0) ? -g_msgs[k] : g_msgs[k];
          if (a > MAGMAX) a = MAGMAX;
          if (a < m) m = a;
          s = s ^ (g_msgs[k] < 0);
        end
      end
      c = corr(m);
      e.idx = j;
      e.msg = s ? -c : c;
      sb_q.push_back(e);
    end
  endfunction

  // out_ready driver: optional forced hold at the start of EMIT, else random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (force_hold > 0 && out_valid) begin
        out_ready = 1'b0;
        force_hold--;
      end else begin
        out_ready = ($urandom_range(99) < rdy_pct);
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks hold stability.
  logic         held_valid = 1'b0;
  logic [W-1:0] held_msg;
  logic [IW-1:0] held_idx;
  always @(negedge clk) begin
    if (rst) begin
      held_valid = 1'b0;
    end else if (out_valid) begin
      if (held_valid) begin
        checks++;
        if (out_msg !== held_msg || out_idx !== held_idx) begin
          errors++;
          $display("FAIL hold_stable actual=%0d:%0d required=%0d:%0d", out_idx,
                   $signed(out_msg), held_idx, $signed(held_msg));
        end
      end
      if (out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected actual=%0d:%0d required=none", out_idx, $signed(out_msg));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (int'($signed(out_msg)) != e.msg || int'(out_idx) != e.idx) begin
            errors++;
            $display("FAIL out_msg actual=%0d:%0d required=%0d:%0d", out_idx,
                     $signed(out_msg), e.idx, e.msg);
          end
        end
        held_valid = 1'b0;
      end else begin
        held_valid = 1'b1;
        held_msg   = out_msg;
        held_idx   = out_idx;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_msg"}, int'(out_msg), 0);
    chk({tag, "_out_idx"}, int'(out_idx), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_deg_err"}, int'(deg_err), 0);
  endtask

  // Issues one row; random start/deg noise during COLLECT must be ignored.
  task automatic run_row(input int d, input int valid_pct);
    int k;
    int n;
    bit hs;
    push_expected(d);
    deg   = DW'(d);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("collect_busy", int'(busy), 1);
    chk("collect_in_ready", int'(in_ready), 1);
    k = 0;
    n = 0;
    while (k < d && n < 3000) begin
      in_valid = ($urandom_range(99) < valid_pct);
      in_msg   = in_valid ? W'(g_msgs[k]) : W'($urandom);
      start    = $urandom_range(1);
      deg      = DW'($urandom_range(2, MAXD));
      hs       = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) k++;
      n++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (k < d) chk("collect_timeout", k, d);
    chk("emit_zero_bubble", int'(out_valid), 1);
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("emit_done_busy", int'(busy), 0);
    chk("idle_out_valid", int'(out_valid), 0);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  task automatic bad_start(input int d);
    deg   = DW'(d);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("deg_err_pulse", int'(deg_err), 1);
    chk("deg_err_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("deg_err_clear", int'(deg_err), 0);
    chk("deg_err_busy2", int'(busy), 0);
  endtask

  task automatic load_req021();
    g_msgs[0] = 5;
    g_msgs[1] = -3;
    g_msgs[2] = 7;
    g_msgs[3] = -2;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    deg      = '0;
    in_valid = 1'b0;
    in_msg   = '0;
`ifdef LDPC_CNU_OFFSET_EN
    beta     = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst_hold");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_release");

`ifdef LDPC_CNU_OFFSET_EN
    g_beta = 1;
    beta   = 5'd1;
    load_req021();
    run_row(4, 100);
    g_beta = 3;
    beta   = 5'd3;
    run_row(4, 100);
    g_beta = 1;
    beta   = 5'd1;
`endif

    load_req021();
    run_row(4, 100);

    g_msgs[0] = -32;
    g_msgs[1] = 4;
    g_msgs[2] = -4;
    run_row(3, 100);

    load_req021();
    force_hold = 5;
    run_row(4, 100);
    run_row(4, 40);

    bad_start(1);
    bad_start(33);
    bad_start(0);

    // Asynchronous reset mid-row, away from a clock edge.
    load_req021();
    deg   = DW'(4);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_msg = W'(g_msgs[i]);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_mid_after");
    run_row(4, 100);

    rdy_pct = 70;
    for (int r = 0; r < 25; r++) begin
      int d;
      d = $urandom_range(2, MAXD);
      for (int i = 0; i < d; i++) g_msgs[i] = int'($urandom_range(63)) - 32;
      run_row(d, 70);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
